// File: rtl/hex_ascii_streamer.sv
// Streams a DATA_W-bit word as ASCII hex characters, MSB nibble first, with optional terminator.
// Define HEX_ASCII_PREFIX_EN to emit a "0x" prefix before the digits.
module hex_ascii_streamer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LOWERCASE = 0,
    parameter int unsigned ADD_TERM  = 1,
    parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned NDIG  = DATA_W / 4;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 64) begin : g_bad_width
        $error("hex_ascii_streamer: DATA_W must be a multiple of 4 in 4..64");
    end

`ifdef HEX_ASCII_PREFIX_EN
    typedef enum logic [2:0] {StIdle, StPrefix0, StPrefix1, StDigits, StTerm} state_t;
`else
    typedef enum logic [1:0] {StIdle, StDigits, StTerm} state_t;
`endif

    state_t            state_q;
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        out_char_q;
    logic              out_valid_q;

    function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'd48 + {4'd0, n};
        end else if (LOWERCASE != 0) begin
            return 8'd87 + {4'd0, n};
        end else begin
            return 8'd55 + {4'd0, n};
        end
    endfunction

    // ASCII of nibble k of word w, i.e. w[4k+3:4k].
    function automatic logic [7:0] digit_at(input logic [DATA_W-1:0] w,
                                            input logic [CNT_W-1:0]  k);
        logic [DATA_W-1:0] sh;
        sh = w >> {k, 2'b00};
        return nibble_ascii(sh[3:0]);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            word_q      <= '0;
            cnt_q       <= '0;
            out_char_q  <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        word_q      <= in_data;
                        cnt_q       <= LAST_DIG;
                        out_valid_q <= 1'b1;
`ifdef HEX_ASCII_PREFIX_EN
                        out_char_q  <= 8'd48;
                        state_q     <= StPrefix0;
`else
                        out_char_q  <= digit_at(in_data, LAST_DIG);
                        state_q     <= StDigits;
`endif
                    end
                end
`ifdef HEX_ASCII_PREFIX_EN
                StPrefix0: begin
                    if (out_ready) begin
                        out_char_q <= 8'd120;
                        state_q    <= StPrefix1;
                    end
                end
                StPrefix1: begin
                    if (out_ready) begin
                        out_char_q <= digit_at(word_q, cnt_q);
                        state_q    <= StDigits;
                    end
                end
`endif
                StDigits: begin
                    if (out_ready) begin
                        if (cnt_q != '0) begin
                            cnt_q      <= cnt_q - CNT_W'(1);
                            out_char_q <= digit_at(word_q, cnt_q - CNT_W'(1));
                        end else if (ADD_TERM != 0) begin
                            out_char_q <= TERM_CHAR;
                            state_q    <= StTerm;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end
                    end
                end
                StTerm: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_char  = out_char_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer: three instances (default, lowercase/no-term, 8-bit).
module tb_hex_ascii_streamer;

    typedef logic [7:0] cq_t[$];
    typedef bit         pq_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic [7:0] oc[3];
    logic       ov[3];
    logic       ir[3];
    logic       bz[3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hex_ascii_streamer dut_def (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[0]), .out_char(oc[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .busy(bz[0])
    );

    hex_ascii_streamer #(.LOWERCASE(1), .ADD_TERM(0)) dut_lc (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[1]), .out_char(oc[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .busy(bz[1])
    );

    hex_ascii_streamer #(.DATA_W(8)) dut_w8 (
        .clock(clock), .reset(reset), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(ir[2]), .out_char(oc[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .busy(bz[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic cq_t rep(input logic [7:0] c, input int n);
        cq_t q;
        for (int i = 0; i < n; i++) q.push_back(c);
        return q;
    endfunction

    function automatic cq_t pfx(input cq_t q);
`ifdef HEX_ASCII_PREFIX_EN
        q.push_front(8'd120);
        q.push_front(8'd48);
`endif
        return q;
    endfunction

    task automatic check_idle(input string tag, input int s);
        check({tag, "_valid"}, 64'(ov[s]), 64'd0);
        check({tag, "_in_ready"}, 64'(ir[s]), 64'd1);
        check({tag, "_busy"}, 64'(bz[s]), 64'd0);
    endtask

    // Called on the negedge right after the accepting edge; consumes the whole word.
    task automatic stream_check(input string tag, input int s, input cq_t e, input pq_t pat);
        int i = 0;
        int step = 0;
        while (i < e.size() && step < e.size() + 16) begin
            check({tag, "_valid"}, 64'(ov[s]), 64'd1);
            check({tag, "_char"}, 64'(oc[s]), 64'(e[i]));
            check({tag, "_busy_in_ready"}, {62'd0, bz[s], ir[s]}, 64'd2);
            out_ready = (step < pat.size()) ? pat[step] : 1'b1;
            @(negedge clock);
            if (out_ready) i++;
            step++;
        end
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(i), 64'(e.size()));
        check_idle({tag, "_end"}, s);
    endtask

    task automatic accept(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        cq_t e;
        pq_t none;
        pq_t pat;

        // Reset values, sampled while reset is still held.
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            check("rst_char", 64'(oc[s]), 64'd0);
            check_idle("rst", s);
        end
        reset = 1'b0;
        @(negedge clock);

        // Basic word, uppercase with terminator.
        accept(32'h1234ABCD);
        e = '{8'd49, 8'd50, 8'd51, 8'd52, 8'd65, 8'd66, 8'd67, 8'd68, 8'd10};
        stream_check("basic", 0, pfx(e), none);

        // Lowercase, no terminator.
        do_reset();
        accept(32'hDEADBEEF);
        e = '{8'd100, 8'd101, 8'd97, 8'd100, 8'd98, 8'd101, 8'd101, 8'd102};
        stream_check("lower", 1, pfx(e), none);

        // Downstream stall pattern 1,0,0,1.
        do_reset();
        accept(32'h00000009);
        pat.push_back(1'b1);
        pat.push_back(1'b0);
        pat.push_back(1'b0);
        pat.push_back(1'b1);
        e = rep(8'd48, 7);
        e.push_back(8'd57);
        e.push_back(8'd10);
        stream_check("stall", 0, pfx(e), pat);

        // Back-to-back words with in_valid held high; second word presented right after accept.
        do_reset();
        in_data  = 32'h0;
        in_valid = 1'b1;
        @(negedge clock);
        in_data = 32'hFFFFFFFF;
        e = rep(8'd48, 8);
        e.push_back(8'd10);
        stream_check("b2b_first", 0, pfx(e), none);
        @(negedge clock);
        in_valid = 1'b0;
        e = rep(8'd70, 8);
        e.push_back(8'd10);
        stream_check("b2b_second", 0, pfx(e), none);

        // Reset after the third character aborts the word.
        do_reset();
        accept(32'h12345678);
        e = pfx('{8'd49, 8'd50, 8'd51});
        for (int i = 0; i < 3; i++) begin
            check("abort_pre_valid", 64'(ov[0]), 64'd1);
            check("abort_pre_char", 64'(oc[0]), 64'(e[i]));
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_char", 64'(oc[0]), 64'd0);
        check_idle("abort", 0);
        reset = 1'b0;
        accept(32'h0000000A);
        e = rep(8'd48, 7);
        e.push_back(8'd65);
        e.push_back(8'd10);
        stream_check("after_abort", 0, pfx(e), none);

        // 8-bit instance.
        do_reset();
        accept(32'h0000007F);
        e = '{8'd55, 8'd70, 8'd10};
        stream_check("w8", 2, pfx(e), none);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
